cache_control_nway: RTL and testbench
=====================================

Name: cache_control_nway

Overview:
- Parametrised successor to the MP2 2-way cache controller FSM; drives the datapath of an N-way set-associative write-back cache between the CPU-side mem_* interface and the pmem_* cacheline interface.
- New versus the 2-way controller:
  - NUM_WAYS-way tree pseudo-LRU with victim selection that prefers invalid ways.
  - Optional no-write-allocate write-through on write misses.
  - Replay lookup after every fill.
  - Multi-hit error detection.
  - Saturating hit/miss counters.

Parameters:
- NUM_WAYS, 4, number of ways; power of 2, range 2..8.
- WAY_W, $clog2(NUM_WAYS), way index width (derived).
- WRITE_ALLOCATE, 1, 1: a write miss fills then writes; 0: a write miss goes write-through with no array update.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  CPU read request; held until mem_resp
- mem_write  in  1  CPU write request; held until mem_resp
- hit  in  NUM_WAYS  per-way tag match AND valid, for the current set
- valid  in  NUM_WAYS  per-way valid bits, current set
- dirty  in  NUM_WAYS  per-way dirty bits, current set
- plru_in  in  NUM_WAYS-1  PLRU tree bits, current set
- pmem_resp  in  1  physical memory done
- mem_resp  out  1  CPU response pulse
- cache_array_read  out  1  array read enable
- way_sel  out  WAY_W  way targeted by load_* signals
- load_valid / load_tag / load_dirty / load_data / load_plru  out  1 each  array write enables
- dirty_in  out  1  value written to dirty[way_sel]
- data_src  out  1  0: CPU write data (byte-enabled); 1: pmem line
- plru_out  out  NUM_WAYS-1  updated PLRU bits
- pmem_read / pmem_write  out  1 each  physical memory request
- pmem_addr_sel  out  1  0: CPU address; 1: {victim tag, set}
- load_wb_buf  out  1  capture the victim line into the writeback buffer
- multi_hit_err  out  1  sticky error flag
- hit_count / miss_count  out  CNT_W each  saturating counters

Behaviour:
- Reset (async, rst_n=0): state = IDLE; all outputs 0; counters 0; multi_hit_err = 0; victim registers 0. Reset mid-miss drops pmem_read/pmem_write in the same cycle.
- PLRU tree:
  - Node i has children 2i+1 / 2i+2; bit = 0 means "go left", bit = 1 means "go right"; leaves are ways 0..NUM_WAYS-1, left to right.
  - Victim = walk from the root following the bits.
  - Touching way w sets every node on w's path to point away from w; off-path bits are copied from plru_in unchanged.
- Victim selection: the lowest-index way with valid = 0 if one exists, otherwise the PLRU victim. Victim index and victim dirty status are registered on the LOOKUP miss cycle and held until the request completes.
- IDLE: cache_array_read = mem_read|mem_write. If a request is present, go to LOOKUP; otherwise stay in IDLE.
- LOOKUP, hit (|hit):
  - way_sel = lowest set bit of hit; multi_hit_err set if popcount(hit) > 1.
  - mem_resp = 1, load_plru = 1, plru_out = touch(way_sel), hit_count += 1.
  - Write hit additionally: load_data = 1, data_src = 0, load_dirty = 1, dirty_in = 1.
  - Next state IDLE; 1-cycle hit latency after the IDLE cycle.
- LOOKUP, miss: miss_count += 1.
  - Write with WRITE_ALLOCATE = 0 → WRITE_THRU.
  - Otherwise, victim valid & dirty → WB_SETUP; else → FILL.
- LOOKUP with no request (request dropped during a miss) → IDLE, no mem_resp, no counter change.
- WB_SETUP (1 cycle): way_sel = victim, pmem_addr_sel = 1, load_wb_buf = 1 → WRITEBACK.
- WRITEBACK:
  - pmem_write = 1, pmem_addr_sel = 1, way_sel = victim.
  - On pmem_resp: load_dirty = 1, dirty_in = 0 → FILL.
- FILL:
  - pmem_read = 1, pmem_addr_sel = 0, way_sel = victim.
  - On pmem_resp: load_data = 1, data_src = 1, load_tag = 1, load_valid = 1, load_dirty = 1, dirty_in = 0 → REPLAY.
- REPLAY (1 cycle): cache_array_read = 1 → LOOKUP. The replayed lookup hits, and the write merge happens there. A hit on a replayed lookup does not increment hit_count.
- WRITE_THRU:
  - pmem_write = 1, pmem_addr_sel = 0; no load_* signals and no PLRU update.
  - On pmem_resp: mem_resp = 1 → IDLE.
- mem_read and mem_write both asserted is illegal; it is treated as a write.
- pmem_read and pmem_write are never asserted in the same cycle.
- Counters stop at 2^CNT_W − 1 (saturate, no wrap).

Test Plan:
- NUM_WAYS = 4, read, hit = 4'b0100, plru_in = 3'b000 → in LOOKUP: mem_resp = 1, way_sel = 2, plru_out = 3'b001 (root points left, node2 points to way 3); hit_count = 1.
- Read miss, valid = 4'b1111, dirty = 4'b0001, plru_in = 3'b000 (victim 0) → sequence WB_SETUP, WRITEBACK (pmem_write held 5 cycles until pmem_resp), dirty cleared, FILL, pmem_resp, REPLAY, LOOKUP hit, mem_resp; pmem_read and pmem_write never overlap.
- Read miss, valid = 4'b1011 → victim way 2 regardless of plru_in; no writeback; FILL directly.
- WRITE_ALLOCATE = 0, write miss → pmem_write with pmem_addr_sel = 0; mem_resp on pmem_resp; no load_* signal asserted; miss_count += 1.
- hit = 4'b0110 → way_sel = 1, multi_hit_err = 1 and remains set afterwards; rst_n pulsed low during FILL → immediate IDLE, all outputs 0.
- CNT_W = 2, 5 read hits → hit_count stops at 3.

Source files
------------

// File: rtl/cache_control_nway.sv
// Controller FSM for an N-way set-associative write-back cache. It sits between the CPU mem_* port
// and the pmem_* cacheline port, and keeps tree pseudo-LRU state, a sticky multi-hit flag and hit/miss counters.
module cache_control_nway #(
    parameter int NUM_WAYS       = 4,
    parameter int WAY_W          = $clog2(NUM_WAYS),
    parameter bit WRITE_ALLOCATE = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [NUM_WAYS-1:0] hit,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [NUM_WAYS-1:0] dirty,
    input  logic [NUM_WAYS-2:0] plru_in,
    input  logic                pmem_resp,
    output logic                mem_resp,
    output logic                cache_array_read,
    output logic [WAY_W-1:0]    way_sel,
    output logic                load_valid,
    output logic                load_tag,
    output logic                load_dirty,
    output logic                load_data,
    output logic                load_plru,
    output logic                dirty_in,
    output logic                data_src,
    output logic [NUM_WAYS-2:0] plru_out,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic                pmem_addr_sel,
    output logic                load_wb_buf,
    output logic                multi_hit_err,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_SETUP, WRITEBACK, FILL, REPLAY, WRITE_THRU
    } state_t;

    state_t           state, state_next;
    logic [WAY_W-1:0] victim_q, hit_way, inv_way, victim_c;
    logic             victim_dirty_q, replaying, inv_found, victim_needs_wb;
    logic             capture_victim, hit_inc, miss_inc, err_set;
    logic             req;

    // Tree node i lives at plru bit NUM_WAYS-2-i, so the root is the MSB.
    function automatic logic [WAY_W-1:0] node_pos(input int node);
        return WAY_W'(NUM_WAYS - 2 - node);
    endfunction

    function automatic logic [WAY_W-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
        logic [WAY_W-1:0] way;
        logic             dir;
        int               node;
        way  = '0;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir  = bits[node_pos(node)];
            way  = (way << 1) | WAY_W'(dir);
            node = 2 * node + 1 + int'(dir);
        end
        return way;
    endfunction

    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                       input logic [WAY_W-1:0]    way);
        logic [NUM_WAYS-2:0] upd;
        logic [WAY_W-1:0]    sh;
        logic                dir;
        int                  node;
        upd  = bits;
        node = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            sh             = way >> (WAY_W - 1 - lvl);
            dir            = sh[0];
            upd[node_pos(node)] = ~dir;
            node           = 2 * node + 1 + int'(dir);
        end
        return upd;
    endfunction

    assign req = mem_read | mem_write;

    // Scanning from the top down leaves the lowest matching index in place.
    always_comb begin
        hit_way   = '0;
        inv_way   = '0;
        inv_found = 1'b0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit[i]) hit_way = WAY_W'(i);
            if (!valid[i]) begin
                inv_way   = WAY_W'(i);
                inv_found = 1'b1;
            end
        end
    end

    assign victim_c        = inv_found ? inv_way : plru_victim(plru_in);
    assign victim_needs_wb = valid[victim_c] & dirty[victim_c];

    // NOTE: every output and flag is given a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next       = state;
        mem_resp         = 1'b0;
        cache_array_read = 1'b0;
        way_sel          = '0;
        load_valid       = 1'b0;
        load_tag         = 1'b0;
        load_dirty       = 1'b0;
        load_data        = 1'b0;
        load_plru        = 1'b0;
        dirty_in         = 1'b0;
        data_src         = 1'b0;
        plru_out         = plru_in;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        pmem_addr_sel    = 1'b0;
        load_wb_buf      = 1'b0;
        capture_victim   = 1'b0;
        hit_inc          = 1'b0;
        miss_inc         = 1'b0;
        err_set          = 1'b0;
        // Outputs are forced low for the whole time reset is held, even if a request is still present.
        if (rst_n) begin
            case (state)
                IDLE: begin
                    cache_array_read = req;
                    if (req) state_next = LOOKUP;
                end
                LOOKUP: begin
                    if (!req) begin
                        state_next = IDLE;
                    end else if (|hit) begin
                        way_sel    = hit_way;
                        err_set    = ($countones(hit) > 1);
                        mem_resp   = 1'b1;
                        load_plru  = 1'b1;
                        plru_out   = plru_touch(plru_in, hit_way);
                        hit_inc    = ~replaying;
                        if (mem_write) begin
                            load_data  = 1'b1;
                            load_dirty = 1'b1;
                            dirty_in   = 1'b1;
                        end
                        state_next = IDLE;
                    end else begin
                        miss_inc       = 1'b1;
                        capture_victim = 1'b1;
                        if (mem_write && !WRITE_ALLOCATE) state_next = WRITE_THRU;
                        else if (victim_needs_wb)         state_next = WB_SETUP;
                        else                              state_next = FILL;
                    end
                end
                WB_SETUP: begin
                    way_sel       = victim_q;
                    pmem_addr_sel = 1'b1;
                    load_wb_buf   = victim_dirty_q;
                    state_next    = WRITEBACK;
                end
                WRITEBACK: begin
                    way_sel       = victim_q;
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        load_dirty = 1'b1;
                        state_next = FILL;
                    end
                end
                FILL: begin
                    way_sel   = victim_q;
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_data  = 1'b1;
                        data_src   = 1'b1;
                        load_tag   = 1'b1;
                        load_valid = 1'b1;
                        load_dirty = 1'b1;
                        state_next = REPLAY;
                    end
                end
                REPLAY: begin
                    cache_array_read = 1'b1;
                    state_next       = LOOKUP;
                end
                WRITE_THRU: begin
                    pmem_write = 1'b1;
                    if (pmem_resp) begin
                        mem_resp   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            victim_q       <= '0;
            victim_dirty_q <= 1'b0;
            replaying      <= 1'b0;
            multi_hit_err  <= 1'b0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            state     <= state_next;
            replaying <= (state == REPLAY);
            if (capture_victim) begin
                victim_q       <= victim_c;
                victim_dirty_q <= victim_needs_wb;
            end
            if (err_set) multi_hit_err <= 1'b1;
            if (hit_inc && hit_count != '1)   hit_count  <= hit_count + CNT_W'(1);
            if (miss_inc && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cache_control_nway.sv
// Bench for cache_control_nway: a behavioural single-set cache model drives the tag/valid/dirty/PLRU inputs
// and predicts every output cycle by cycle. Three instances are used: default, CNT_W=2, and no-write-allocate.
module tb_cache_control_nway;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read, mem_write, pmem_resp;
    logic [3:0] hit, valid, dirty;
    logic [2:0] plru_in;

    logic        mem_resp, cache_array_read, load_valid, load_tag, load_dirty, load_data, load_plru;
    logic        dirty_in, data_src, pmem_read, pmem_write, pmem_addr_sel, load_wb_buf, multi_hit_err;
    logic [1:0]  way_sel;
    logic [2:0]  plru_out;
    logic [15:0] hit_count, miss_count;

    logic        s_mem_resp, s_cache_array_read, s_load_valid, s_load_tag, s_load_dirty, s_load_data, s_load_plru;
    logic        s_dirty_in, s_data_src, s_pmem_read, s_pmem_write, s_pmem_addr_sel, s_load_wb_buf, s_multi_hit_err;
    logic [1:0]  s_way_sel;
    logic [2:0]  s_plru_out;
    logic [1:0]  s_hit_count, s_miss_count;

    logic        w_mem_read, w_mem_write, w_pmem_resp;
    logic [3:0]  w_hit, w_valid, w_dirty;
    logic [2:0]  w_plru_in;
    logic        w_mem_resp, w_cache_array_read, w_load_valid, w_load_tag, w_load_dirty, w_load_data, w_load_plru;
    logic        w_dirty_in, w_data_src, w_pmem_read, w_pmem_write, w_pmem_addr_sel, w_load_wb_buf, w_multi_hit_err;
    logic [1:0]  w_way_sel;
    logic [2:0]  w_plru_out;
    logic [15:0] w_hit_count, w_miss_count;

    always #5 clk = ~clk;

    cache_control_nway #(.NUM_WAYS(4), .WRITE_ALLOCATE(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .hit(hit), .valid(valid),
        .dirty(dirty), .plru_in(plru_in), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
        .cache_array_read(cache_array_read), .way_sel(way_sel), .load_valid(load_valid), .load_tag(load_tag),
        .load_dirty(load_dirty), .load_data(load_data), .load_plru(load_plru), .dirty_in(dirty_in),
        .data_src(data_src), .plru_out(plru_out), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .load_wb_buf(load_wb_buf), .multi_hit_err(multi_hit_err),
        .hit_count(hit_count), .miss_count(miss_count));

    cache_control_nway #(.NUM_WAYS(4), .WRITE_ALLOCATE(1'b1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .hit(hit), .valid(valid),
        .dirty(dirty), .plru_in(plru_in), .pmem_resp(pmem_resp), .mem_resp(s_mem_resp),
        .cache_array_read(s_cache_array_read), .way_sel(s_way_sel), .load_valid(s_load_valid),
        .load_tag(s_load_tag), .load_dirty(s_load_dirty), .load_data(s_load_data), .load_plru(s_load_plru),
        .dirty_in(s_dirty_in), .data_src(s_data_src), .plru_out(s_plru_out), .pmem_read(s_pmem_read),
        .pmem_write(s_pmem_write), .pmem_addr_sel(s_pmem_addr_sel), .load_wb_buf(s_load_wb_buf),
        .multi_hit_err(s_multi_hit_err), .hit_count(s_hit_count), .miss_count(s_miss_count));

    cache_control_nway #(.NUM_WAYS(4), .WRITE_ALLOCATE(1'b0), .CNT_W(16)) dut_wt (
        .clk(clk), .rst_n(rst_n), .mem_read(w_mem_read), .mem_write(w_mem_write), .hit(w_hit),
        .valid(w_valid), .dirty(w_dirty), .plru_in(w_plru_in), .pmem_resp(w_pmem_resp),
        .mem_resp(w_mem_resp), .cache_array_read(w_cache_array_read), .way_sel(w_way_sel),
        .load_valid(w_load_valid), .load_tag(w_load_tag), .load_dirty(w_load_dirty), .load_data(w_load_data),
        .load_plru(w_load_plru), .dirty_in(w_dirty_in), .data_src(w_data_src), .plru_out(w_plru_out),
        .pmem_read(w_pmem_read), .pmem_write(w_pmem_write), .pmem_addr_sel(w_pmem_addr_sel),
        .load_wb_buf(w_load_wb_buf), .multi_hit_err(w_multi_hit_err), .hit_count(w_hit_count),
        .miss_count(w_miss_count));

    typedef struct packed {
        logic       mem_resp;
        logic       car;
        logic [1:0] way;
        logic       lv, lt, ld, ldat, lplru, din, dsrc;
        logic [2:0] plru;
        logic       pr, pw, pas, lwb;
    } outs_t;
    localparam int OW = $bits(outs_t);

    int         n_tests = 0;
    int         n_fail  = 0;
    outs_t      exp_o, care_o;
    logic [1:0] last_way;
    logic [2:0] last_plru;

    // Behavioural model of the one set being exercised.
    logic [7:0] m_tag[4];
    bit         m_valid[4];
    bit         m_dirty[4];
    logic [2:0] m_plru;
    int         m_hits, m_misses;
    bit         m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic outs_t obs_main();
        outs_t o;
        o = '{mem_resp, cache_array_read, way_sel, load_valid, load_tag, load_dirty, load_data, load_plru,
              dirty_in, data_src, plru_out, pmem_read, pmem_write, pmem_addr_sel, load_wb_buf};
        return o;
    endfunction

    function automatic outs_t obs_sat();
        outs_t o;
        o = '{s_mem_resp, s_cache_array_read, s_way_sel, s_load_valid, s_load_tag, s_load_dirty, s_load_data,
              s_load_plru, s_dirty_in, s_data_src, s_plru_out, s_pmem_read, s_pmem_write, s_pmem_addr_sel,
              s_load_wb_buf};
        return o;
    endfunction

    function automatic outs_t obs_wt();
        outs_t o;
        o = '{w_mem_resp, w_cache_array_read, w_way_sel, w_load_valid, w_load_tag, w_load_dirty, w_load_data,
              w_load_plru, w_dirty_in, w_data_src, w_plru_out, w_pmem_read, w_pmem_write, w_pmem_addr_sel,
              w_load_wb_buf};
        return o;
    endfunction

    // way_sel, dirty_in, data_src and plru_out are only compared where the behaviour defines them.
    task automatic exp_clear();
        exp_o       = '0;
        care_o      = '1;
        care_o.way  = '0;
        care_o.din  = 1'b0;
        care_o.dsrc = 1'b0;
        care_o.plru = '0;
    endtask

    task automatic check_outs(input string tag, input outs_t o);
        logic [OW-1:0] ov, ev, cv;
        ov = o;
        ev = exp_o;
        cv = care_o;
        check(tag, 32'(ov & cv), 32'(ev & cv));
    endtask

    task automatic check_cycle(input string tag);
        check_outs(tag, obs_main());
        check_outs({tag, "_sat"}, obs_sat());
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Victim: lowest invalid way, else walk the tree by halving the way interval.
    function automatic int model_victim();
        int lo, hi, node, mid;
        for (int i = 3; i >= 0; i--) if (!m_valid[i]) lo = i;
        if (m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3]) begin
            lo = 0; hi = 4; node = 0;
            while (hi - lo > 1) begin
                mid = (lo + hi) / 2;
                if (((m_plru >> (2 - node)) & 3'b001) != 3'b000) begin lo = mid; node = 2 * node + 2; end
                else begin hi = mid; node = 2 * node + 1; end
            end
        end
        return lo;
    endfunction

    function automatic logic [2:0] model_touch(input logic [2:0] p, input int w);
        int lo, hi, node, mid;
        lo = 0; hi = 4; node = 0;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w >= mid) begin p = p & ~(3'b001 << (2 - node)); lo = mid; node = 2 * node + 2; end
            else begin p = p | (3'b001 << (2 - node)); hi = mid; node = 2 * node + 1; end
        end
        return p;
    endfunction

    task automatic drive_arrays(input logic [7:0] tg);
        for (int i = 0; i < 4; i++) begin
            hit[i]   = m_valid[i] && (m_tag[i] == tg);
            valid[i] = m_valid[i];
            dirty[i] = m_dirty[i];
        end
        plru_in = m_plru;
    endtask

    task automatic set_set(input logic [7:0] t0, t1, t2, t3, input logic [3:0] v, d, input logic [2:0] p);
        m_tag[0] = t0; m_tag[1] = t1; m_tag[2] = t2; m_tag[3] = t3;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = v[i];
            m_dirty[i] = d[i];
        end
        m_plru = p;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_hit_count"}, 32'(hit_count), m_hits);
        check({tag, "_miss_count"}, 32'(miss_count), m_misses);
        check({tag, "_sat_hit_count"}, 32'(s_hit_count), sat3(m_hits));
        check({tag, "_sat_miss_count"}, 32'(s_miss_count), sat3(m_misses));
        check({tag, "_multi_hit_err"}, 32'(multi_hit_err), 32'(m_err));
        check({tag, "_sat_multi_hit_err"}, 32'(s_multi_hit_err), 32'(m_err));
    endtask

    // One CPU request from IDLE to mem_resp, following the model's timing; the DUT is never waited on.
    task automatic run_req(input bit wr, input logic [7:0] tg, input int wb_wait, input int fill_wait);
        int nh, hw, v;
        bit replay, done;
        replay = 1'b0;
        done   = 1'b0;
        @(negedge clk);
        mem_read = !wr; mem_write = wr; pmem_resp = 1'b0;
        drive_arrays(tg);
        #1;
        exp_clear(); exp_o.car = 1'b1;
        check_cycle("idle_req");
        for (int pass = 0; pass < 2 && !done; pass++) begin
            @(negedge clk);
            pmem_resp = 1'b0;
            drive_arrays(tg);
            #1;
            nh = 0; hw = 0;
            for (int i = 3; i >= 0; i--) if (m_valid[i] && m_tag[i] == tg) begin nh++; hw = i; end
            exp_clear();
            if (nh > 0) begin
                exp_o.mem_resp = 1'b1; exp_o.lplru = 1'b1;
                exp_o.way = 2'(hw); care_o.way = '1;
                m_plru = model_touch(m_plru, hw);
                exp_o.plru = m_plru; care_o.plru = '1;
                if (wr) begin
                    exp_o.ldat = 1'b1; exp_o.ld = 1'b1; exp_o.din = 1'b1; exp_o.dsrc = 1'b0;
                    care_o.din = 1'b1; care_o.dsrc = 1'b1;
                    m_dirty[hw] = 1'b1;
                end
                if (!replay) m_hits++;
                if (nh > 1) m_err = 1'b1;
                check_cycle(replay ? "replay_lookup_hit" : "lookup_hit");
                last_way  = way_sel;
                last_plru = plru_out;
                done      = 1'b1;
            end else begin
                m_misses++;
                v = model_victim();
                check_cycle("lookup_miss");
                if (m_valid[v] && m_dirty[v]) begin
                    @(negedge clk); drive_arrays(tg); #1;
                    exp_clear(); exp_o.way = 2'(v); care_o.way = '1; exp_o.pas = 1'b1; exp_o.lwb = 1'b1;
                    check_cycle("wb_setup");
                    for (int k = 0; k <= wb_wait; k++) begin
                        @(negedge clk); pmem_resp = (k == wb_wait); drive_arrays(tg); #1;
                        exp_clear(); exp_o.pw = 1'b1; exp_o.pas = 1'b1; exp_o.way = 2'(v); care_o.way = '1;
                        if (k == wb_wait) begin exp_o.ld = 1'b1; care_o.din = 1'b1; end
                        check_cycle("writeback");
                    end
                    m_dirty[v] = 1'b0;
                end
                for (int k = 0; k <= fill_wait; k++) begin
                    @(negedge clk); pmem_resp = (k == fill_wait); drive_arrays(tg); #1;
                    exp_clear(); exp_o.pr = 1'b1; exp_o.way = 2'(v); care_o.way = '1;
                    if (k == fill_wait) begin
                        exp_o.ldat = 1'b1; exp_o.dsrc = 1'b1; care_o.dsrc = 1'b1;
                        exp_o.lt = 1'b1; exp_o.lv = 1'b1; exp_o.ld = 1'b1; care_o.din = 1'b1;
                    end
                    check_cycle("fill");
                end
                m_tag[v] = tg; m_valid[v] = 1'b1; m_dirty[v] = 1'b0;
                @(negedge clk); pmem_resp = 1'b0; drive_arrays(tg); #1;
                exp_clear(); exp_o.car = 1'b1;
                check_cycle("replay");
                replay = 1'b1;
            end
        end
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        #1;
        exp_clear();
        check_cycle("idle_quiet");
        check_status("after_req");
    endtask

    initial begin
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        hit = '0; valid = '0; dirty = '0; plru_in = '0;
        w_mem_read = 1'b0; w_mem_write = 1'b0; w_pmem_resp = 1'b0;
        w_hit = '0; w_valid = '0; w_dirty = '0; w_plru_in = '0;
        m_hits = 0; m_misses = 0; m_err = 1'b0;
        last_way = '0; last_plru = '0;
        set_set(8'd10, 8'd11, 8'd12, 8'd13, 4'b1111, 4'b0000, 3'b000);
        #1;
        exp_clear();
        check_cycle("reset_outs");
        check_status("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Read hit on way 2 from a cleared tree.
        run_req(1'b0, 8'd12, 0, 0);
        check("tp1_way_sel", 32'(last_way), 32'd2);
        check("tp1_plru_out", 32'(last_plru), 32'b001);

        // Dirty PLRU victim 0: writeback held 5 cycles, then fill and replay.
        set_set(8'd10, 8'd11, 8'd12, 8'd13, 4'b1111, 4'b0001, 3'b000);
        run_req(1'b0, 8'd50, 4, 2);
        check("tp2_way_sel", 32'(last_way), 32'd0);

        // Invalid way 2 wins regardless of the tree.
        set_set(8'd50, 8'd11, 8'd12, 8'd13, 4'b1011, 4'b0100, 3'b111);
        run_req(1'b0, 8'd60, 0, 3);
        check("tp3_way_sel", 32'(last_way), 32'd2);

        run_req(1'b1, 8'd60, 0, 0);
        run_req(1'b1, 8'd70, 1, 1);

        // Request withdrawn before the lookup.
        @(negedge clk);
        mem_read = 1'b1; drive_arrays(8'd99); #1;
        exp_clear(); exp_o.car = 1'b1;
        check_cycle("drop_idle");
        @(negedge clk);
        mem_read = 1'b0; #1;
        exp_clear();
        check_cycle("drop_lookup");
        @(negedge clk); #1;
        check_cycle("drop_after");
        check_status("drop");

        // Two ways match: lowest index served, error latched and kept.
        set_set(8'd30, 8'd31, 8'd31, 8'd33, 4'b1111, 4'b0000, 3'b000);
        run_req(1'b0, 8'd31, 0, 0);
        check("multi_way_sel", 32'(last_way), 32'd1);
        check("multi_err_set", 32'(multi_hit_err), 32'd1);
        run_req(1'b0, 8'd30, 0, 0);

        // No-write-allocate instance: write miss goes straight to pmem with the CPU address.
        @(negedge clk);
        w_mem_write = 1'b1; w_valid = 4'b1111; w_dirty = 4'b1111; w_hit = '0; w_plru_in = 3'b000; #1;
        exp_clear(); exp_o.car = 1'b1;
        check_outs("wt_idle", obs_wt());
        @(negedge clk); #1;
        exp_clear();
        check_outs("wt_lookup_miss", obs_wt());
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk); w_pmem_resp = (k == 3); #1;
            exp_clear(); exp_o.pw = 1'b1; exp_o.mem_resp = (k == 3);
            check_outs("wt_write_thru", obs_wt());
        end
        @(negedge clk);
        w_mem_write = 1'b0; w_pmem_resp = 1'b0; #1;
        exp_clear();
        check_outs("wt_idle_quiet", obs_wt());
        check("wt_miss_count", 32'(w_miss_count), 32'd1);
        check("wt_hit_count", 32'(w_hit_count), 32'd0);
        check("wt_multi_hit_err", 32'(w_multi_hit_err), 32'd0);

        // Reset asserted in the middle of a fill.
        set_set(8'd20, 8'd21, 8'd22, 8'd23, 4'b1111, 4'b0000, 3'b000);
        @(negedge clk);
        mem_read = 1'b1; drive_arrays(8'd99); #1;
        exp_clear(); exp_o.car = 1'b1;
        check_cycle("rst_idle");
        @(negedge clk); #1;
        exp_clear();
        check_cycle("rst_lookup_miss");
        m_misses++;
        @(negedge clk); #1;
        exp_clear(); exp_o.pr = 1'b1; exp_o.way = 2'd0; care_o.way = '1;
        check_cycle("rst_fill");
        #1;
        rst_n = 1'b0;
        #1;
        m_hits = 0; m_misses = 0; m_err = 1'b0;
        exp_clear();
        check_cycle("rst_mid_fill_outs");
        check_status("rst_mid_fill");
        @(negedge clk);
        mem_read = 1'b0;
        rst_n = 1'b1;

        // Five hits: 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) run_req(1'b0, 8'd21, 0, 0);
        check("sat_hit_count_final", 32'(s_hit_count), 32'd3);
        check("main_hit_count_final", 32'(hit_count), 32'd5);

        // Random traffic over a small tag pool, starting from an empty set.
        set_set(8'd0, 8'd0, 8'd0, 8'd0, 4'b0000, 4'b0000, 3'($urandom_range(0, 7)));
        for (int i = 0; i < 40; i++)
            run_req(1'($urandom_range(0, 1)), 8'(40 + $urandom_range(0, 5)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
